// File: rtl/lsu_mem_ctrl_if.sv
// Request, data-memory bus and response signals of the MEM-stage load/store unit.
// The slave view belongs to the unit; the master view is the core pipeline plus memory.
interface lsu_mem_ctrl_if #(
  parameter int XLEN = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [XLEN-1:0]   req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic [4:0]        req_rd;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_ack;
  logic [XLEN-1:0]   mem_rdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic [4:0]        resp_rd;
  logic [1:0]        resp_err;

  modport slave (
    input  req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ack, mem_rdata,
    output resp_valid, resp_rdata, resp_rd, resp_err,
    input  resp_ready
  );

  modport master (
    output req_valid, req_is_load, req_is_store, req_funct3, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ack, mem_rdata,
    input  resp_valid, resp_rdata, resp_rd, resp_err,
    output resp_ready
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Sequential MEM-stage load/store unit: one request at a time, word-aligned bus with
// byte strobes, load alignment/extension, and misaligned/illegal/timeout error reporting.
module lsu_mem_ctrl #(
  parameter int XLEN          = 32,
  parameter int TIMEOUT       = 255,
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  lsu_mem_ctrl_if.slave   bus,
  output logic            busy
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SIW  = $clog2(XLEN);
  localparam int CW   = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, ERR, RESP} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NB-1:0]     wstrb_q, wstrb_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [OFFW-1:0]   off_q, off_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic [1:0]        err_q, err_d;

  logic              legal;
  logic              misaligned;
  logic [OFFW-1:0]   lane_mask;
  logic [OFFW-1:0]   off_w;
  logic [NB-1:0]     size_strb;
  logic [XLEN-1:0]   shifted_rd;
  logic [XLEN-1:0]   ext_mask;
  logic [XLEN-1:0]   load_ext;
  logic [SIW-1:0]    sign_idx;
  logic              sign_bit;

  // Request decode: legality, size-derived masks and lane offset of the incoming access.
  always_comb begin
    legal = 1'b0;
    if (bus.req_is_load && !bus.req_is_store) begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = (XLEN == 64);
        default:                                legal = 1'b0;
      endcase
    end else if (bus.req_is_store && !bus.req_is_load) begin
      case (bus.req_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = (XLEN == 64);
        default:                legal = 1'b0;
      endcase
    end

    case (bus.req_funct3[1:0])
      2'd0:    begin lane_mask = OFFW'(0); size_strb = NB'(8'h01); end
      2'd1:    begin lane_mask = OFFW'(1); size_strb = NB'(8'h03); end
      2'd2:    begin lane_mask = OFFW'(3); size_strb = NB'(8'h0F); end
      default: begin lane_mask = OFFW'(7); size_strb = NB'(8'hFF); end
    endcase

    misaligned = |(bus.req_addr[OFFW-1:0] & lane_mask);
    off_w      = bus.req_addr[OFFW-1:0];
    if (!MISALIGN_TRAP) off_w = off_w & ~lane_mask;
  end

  // Load data: shift the addressed field down, then sign- or zero-extend by size.
  always_comb begin
    shifted_rd = bus.mem_rdata >> {off_q, 3'b000};
    ext_mask   = {XLEN{1'b1}} << (8 << funct3_q[1:0]);
    sign_idx   = SIW'((8 << funct3_q[1:0]) - 1);
    sign_bit   = shifted_rd[sign_idx] & ~funct3_q[2];
    load_ext   = sign_bit ? (shifted_rd | ext_mask) : (shifted_rd & ~ext_mask);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wstrb_d  = wstrb_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d     = bus.req_is_store;
          addr_d   = {bus.req_addr[XLEN-1:OFFW], OFFW'(0)};
          wstrb_d  = bus.req_is_store ? (size_strb << off_w) : '0;
          wdata_d  = bus.req_is_store ? (bus.req_wdata << {off_w, 3'b000}) : '0;
          off_d    = off_w;
          funct3_d = bus.req_funct3;
          rd_d     = (bus.req_is_load && !bus.req_is_store) ? bus.req_rd : 5'd0;
          rdata_d  = '0;
          err_d    = 2'd0;
          cnt_d    = '0;
          if (!legal) begin
            err_d   = 2'd2;
            state_d = ERR;
          end else if (misaligned && MISALIGN_TRAP) begin
            err_d   = 2'd1;
            state_d = ERR;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          rdata_d = we_q ? '0 : load_ext;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 2'd3;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ERR: begin
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wstrb_q  <= '0;
      wdata_q  <= '0;
      off_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      rdata_q  <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wstrb_q  <= wstrb_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Bus and response outputs are forced to zero outside the states that own them.
  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    busy           = (state_q != IDLE);
    bus.mem_req    = (state_q == ACCESS);
    bus.mem_we     = bus.mem_req & we_q;
    bus.mem_addr   = bus.mem_req ? addr_q  : '0;
    bus.mem_wstrb  = bus.mem_req ? wstrb_q : '0;
    bus.mem_wdata  = bus.mem_req ? wdata_q : '0;
    bus.resp_valid = (state_q == RESP);
    bus.resp_rdata = bus.resp_valid ? rdata_q : '0;
    bus.resp_rd    = bus.resp_valid ? rd_q    : 5'd0;
    bus.resp_err   = bus.resp_valid ? err_q   : 2'd0;
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl (XLEN=32, TIMEOUT=4): a table of requests with
// hand-derived bus/response expectations, a response scoreboard, and reset/backpressure sequences.
module tb_lsu_mem_ctrl;

  localparam int XLEN = 32;
  localparam int TO   = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  int checks = 0;
  int passes = 0;

  // Free-running clock; inputs change #1 after the rising edge, outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  lsu_mem_ctrl_if #(.XLEN(XLEN)) bus ();

  lsu_mem_ctrl #(
    .XLEN(XLEN),
    .TIMEOUT(TO),
    .MISALIGN_TRAP(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave),
    .busy(busy)
  );

  typedef struct {
    logic [XLEN-1:0] rdata;
    logic [4:0]      rd;
    logic [1:0]      err;
    int              lat;
  } exp_t;

  typedef struct {
    logic            ld;
    logic            st;
    logic [2:0]      f3;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [4:0]      rd;
    logic [31:0]     mrdata;
    int              ack_n;
    logic [31:0]     e_addr;
    logic            e_we;
    logic [3:0]      e_strb;
    logic [31:0]     e_wdata;
    logic [31:0]     e_rdata;
    logic [4:0]      e_rd;
    logic [1:0]      e_err;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic idleInputs();
    bus.req_valid    = 1'b0;
    bus.req_is_load  = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'd0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.req_rd       = 5'd0;
    bus.mem_ack      = 1'b0;
    bus.mem_rdata    = '0;
  endtask

  task automatic driveReq(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    bus.req_valid    = 1'b1;
    bus.req_is_load  = ld;
    bus.req_is_store = st;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_rd       = rd;
  endtask

  // One table entry: offer the request, play the memory side, then score the response.
  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    int   mreq_n;
    int   got;
    int   exp_mreq;
    @(negedge clk);
    checkOutput($sformatf("v%0d req_ready", idx), bus.req_ready, 1);
    driveReq(v.ld, v.st, v.f3, v.addr, v.wdata, v.rd);
    exp_mreq = (v.e_err == 2'd1 || v.e_err == 2'd2) ? 0 : (v.ack_n == 0 ? TO : v.ack_n);
    e.rdata  = v.e_rdata;
    e.rd     = v.e_rd;
    e.err    = v.e_err;
    e.lat    = (exp_mreq == 0) ? 2 : exp_mreq + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    mreq_n = 0;
    got    = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      if (i == v.ack_n) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = v.mrdata;
      end
      @(negedge clk);
      if (bus.mem_req) begin
        mreq_n++;
        checkOutput($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.e_addr);
        checkOutput($sformatf("v%0d mem_we", idx), bus.mem_we, v.e_we);
        checkOutput($sformatf("v%0d mem_wstrb", idx), bus.mem_wstrb, v.e_strb);
        checkOutput($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.e_wdata);
      end
      if (bus.resp_valid) begin
        got = 1;
        if (sb_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL v%0d scoreboard: got unexpected response, expected none", idx);
        end else begin
          e = sb_q.pop_front();
          checkOutput($sformatf("v%0d resp_rdata", idx), bus.resp_rdata, e.rdata);
          checkOutput($sformatf("v%0d resp_rd", idx), bus.resp_rd, e.rd);
          checkOutput($sformatf("v%0d resp_err", idx), bus.resp_err, e.err);
          checkOutput($sformatf("v%0d latency", idx), i, e.lat);
        end
      end
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
    end
    if (got == 0) begin
      checks++;
      $display("[TB] FAIL v%0d response: got none within 20 cycles, expected resp_valid", idx);
      sb_q.delete();
    end
    checkOutput($sformatf("v%0d mem_req cycles", idx), mreq_n, exp_mreq);
  endtask

  initial begin
    int   got;
    int   lat;
    exp_t e;

    // ld st f3 addr wdata rd mrdata ack_n | e_addr we strb e_wdata e_rdata e_rd e_err
    vecs[0]  = '{1, 0, 3'b000, 32'h1002, 32'h0, 5, 32'h80FF_7F01, 3, 32'h1000, 0, 4'b0000, 32'h0, 32'hFFFF_FFFF, 5, 0};
    vecs[1]  = '{1, 0, 3'b101, 32'h1002, 32'h0, 6, 32'h80FF_7F01, 1, 32'h1000, 0, 4'b0000, 32'h0, 32'h0000_80FF, 6, 0};
    vecs[2]  = '{0, 1, 3'b000, 32'h2003, 32'h1234_56AB, 8, 32'hFFFF_FFFF, 2, 32'h2000, 1, 4'b1000, 32'hAB00_0000, 32'h0, 0, 0};
    vecs[3]  = '{0, 1, 3'b010, 32'h3002, 32'h1111_2222, 9, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 1};
    vecs[4]  = '{1, 0, 3'b111, 32'h4000, 32'h0, 7, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 7, 2};
    vecs[5]  = '{1, 0, 3'b001, 32'h1002, 32'h0, 10, 32'h80FF_7F01, 2, 32'h1000, 0, 4'b0000, 32'h0, 32'hFFFF_80FF, 10, 0};
    vecs[6]  = '{1, 0, 3'b010, 32'h1004, 32'h0, 31, 32'hDEAD_BEEF, 4, 32'h1004, 0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 31, 0};
    vecs[7]  = '{0, 1, 3'b001, 32'h2002, 32'h0000_BEEF, 2, 32'h5555_5555, 1, 32'h2000, 1, 4'b1100, 32'hBEEF_0000, 32'h0, 0, 0};
    vecs[8]  = '{1, 0, 3'b100, 32'h1003, 32'h0, 11, 32'h80FF_7F01, 1, 32'h1000, 0, 4'b0000, 32'h0, 32'h0000_0080, 11, 0};
    vecs[9]  = '{1, 0, 3'b001, 32'h1001, 32'h0, 3, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 3, 1};
    vecs[10] = '{1, 1, 3'b000, 32'h1000, 32'h0, 12, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 2};
    vecs[11] = '{0, 0, 3'b000, 32'h1000, 32'h0, 13, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 0, 2};
    vecs[12] = '{1, 0, 3'b011, 32'h1000, 32'h0, 4, 32'h0, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 4, 2};
    vecs[13] = '{1, 0, 3'b010, 32'h5000, 32'h0, 9, 32'h0, 0, 32'h5000, 0, 4'b0000, 32'h0, 32'h0, 9, 3};
    vecs[14] = '{0, 1, 3'b010, 32'h6000, 32'hCAFE_F00D, 1, 32'h0, 2, 32'h6000, 1, 4'b1111, 32'hCAFE_F00D, 32'h0, 0, 0};

    idleInputs();
    bus.resp_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset req_ready", bus.req_ready, 1);
    checkOutput("reset mem_req", bus.mem_req, 0);
    checkOutput("reset resp_valid", bus.resp_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset mem_wstrb", bus.mem_wstrb, 0);

    for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of an access, then a stray ack that must be ignored in IDLE.
    @(negedge clk);
    driveReq(1, 0, 3'b010, 32'h7000, 32'h0, 14);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("midaccess mem_req", bus.mem_req, 1);
    checkOutput("midaccess busy", busy, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midreset mem_req", bus.mem_req, 0);
    checkOutput("midreset resp_valid", bus.resp_valid, 0);
    checkOutput("midreset req_ready", bus.req_ready, 1);
    checkOutput("midreset busy", busy, 0);
    @(posedge clk);
    #1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("late ack resp_valid", bus.resp_valid, 0);
    checkOutput("late ack busy", busy, 0);
    checkOutput("late ack req_ready", bus.req_ready, 1);

    // Timeout with response backpressure: fields must hold until resp_ready returns.
    bus.resp_ready = 1'b0;
    @(negedge clk);
    driveReq(1, 0, 3'b010, 32'h5004, 32'h0, 12);
    e.rdata = '0;
    e.rd    = 5'd12;
    e.err   = 2'd3;
    e.lat   = TO + 1;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    got = 0;
    lat = 0;
    for (int i = 1; i <= 20 && got == 0; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        got = 1;
        lat = i;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (got == 0) begin
      checks++;
      $display("[TB] FAIL backpressure response: got none within 20 cycles, expected resp_valid");
    end else begin
      e = sb_q.pop_front();
      checkOutput("bp latency", lat, e.lat);
      for (int c = 0; c < 5; c++) begin
        checkOutput($sformatf("bp c%0d resp_valid", c), bus.resp_valid, 1);
        checkOutput($sformatf("bp c%0d resp_err", c), bus.resp_err, e.err);
        checkOutput($sformatf("bp c%0d resp_rdata", c), bus.resp_rdata, e.rdata);
        checkOutput($sformatf("bp c%0d resp_rd", c), bus.resp_rd, e.rd);
        checkOutput($sformatf("bp c%0d req_ready", c), bus.req_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
      end
      bus.resp_ready = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("bp after resp_valid", bus.resp_valid, 0);
      checkOutput("bp after req_ready", bus.req_ready, 1);
      checkOutput("bp after busy", busy, 0);
    end
    checkOutput("scoreboard empty", sb_q.size(), 0);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
